// File: rtl/wbs_uart_pkg.sv
// rtl/wbs_uart_pkg.sv - shared encodings for the Wishbone UART transmitter
package wbs_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_LVL_LSB = 3;
    localparam int STAT_LVL_MAX = 31;

endpackage

// File: rtl/wbs_uart_fifo.sv
// rtl/wbs_uart_fifo.sv - synchronous FIFO with extra-MSB pointers
module wbs_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/wbs_uart_tx_fifo.sv
// rtl/wbs_uart_tx_fifo.sv - Wishbone pipelined UART transmitter with write FIFO
module wbs_uart_tx_fifo
    import wbs_uart_pkg::*;
#(
    parameter int TICKS_PER_BAUD = 16,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       wbs_clk_i,
    input  logic       wbs_rst_ni,
    input  logic       wbs_stb_i,
    input  logic       wbs_we_i,
    input  logic [7:0] wbs_dat_i,
    output logic [7:0] wbs_dat_o,
    output logic       wbs_ack_o,
    output logic       wbs_stall_o,
    output logic       uart_tx
);
    localparam int         CW        = $clog2(TICKS_PER_BAUD);
    localparam int         LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

    logic          accept, wr_push;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [31:0]   level_ext;
    logic [4:0]    level_sat;
    logic [7:0]    status;

    logic          ack_q;
    logic [7:0]    dat_q, dat_d;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          bit_end, load, tx_c;

    assign wbs_stall_o = fifo_full && wbs_we_i;
    assign accept      = wbs_stb_i && !wbs_stall_o;
    assign wr_push     = accept && wbs_we_i;

    // Unused high character bits are zeroed on entry so parity can span all 8 bits.
    wbs_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wbs_clk_i),
        .rst_ni  (wbs_rst_ni),
        .push_i  (wr_push),
        .pop_i   (fifo_pop),
        .din_i   (wbs_dat_i & DATA_MASK),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        level_ext = 32'(fifo_level);
        level_sat = (level_ext > 32'(STAT_LVL_MAX)) ? 5'(STAT_LVL_MAX) : level_ext[4:0];
        status                 = '0;
        status[STAT_BUSY]      = (state_q != ST_IDLE);
        status[STAT_FULL]      = fifo_full;
        status[STAT_EMPTY]     = fifo_empty;
        status[7:STAT_LVL_LSB] = level_sat;
        dat_d = (accept && !wbs_we_i) ? status : 8'h00;
    end

    // Reset value of the read register mirrors the idle, empty status word.
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= 8'h04;
        end else begin
            ack_q <= accept;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    assign bit_end = (cnt_q == CW'(TICKS_PER_BAUD - 1));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        tx_c       = 1'b1;
        cnt_d      = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                tx_c = 1'b0;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_c = shift_q[0];
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1))
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_c = par_q;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_idx_q) stop_idx_d = 1'b1;
                    else if (!fifo_empty)              load       = 1'b1;
                    else                               state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared by IDLE and the end of STOP so queued characters follow without a gap.
        if (load) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_dout;
            par_d      = (^fifo_dout) ^ (PARITY == PARITY_ODD);
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            state_d    = ST_START;
        end
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
        if (!wbs_rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
        end
    end

    assign uart_tx = tx_c;

endmodule
